clk_gen_ctrl: RTL and testbench

CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

---
 rtl/clk_gen_ctrl.sv | 160 ++++++++++++++++
 tb/tb_clk_gen_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_ctrl.sv
// Programmable clock generator: period/high/phase timed by one down-counter in a 4-state FSM.
// Optional 32-bit rising-edge counter on port cycle_cnt when CLK_GEN_CTRL_CYCLE_CNT_EN is defined.
module clk_gen_ctrl #(
    parameter int CW = 16
) (
    input  logic          ref_clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_period,
    input  logic [CW-1:0] cfg_high,
    input  logic [CW-1:0] cfg_phase,
    input  logic          start,
    input  logic          stop,
    output logic          clk_out,
    output logic          busy,
    output logic          cfg_err
`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] TWO = CW'(2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] high_q, high_d;
    logic [CW-1:0] phase_q, phase_d;
    logic          loaded_q, loaded_d;
    logic          pend_q, pend_d;
    logic          err_q, err_d;
    logic          clk_out_q;
    logic          cfg_ok;
    logic          pend_now;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - ONE : cnt_q;
        period_d = period_q;
        high_d   = high_q;
        phase_d  = phase_q;
        loaded_d = loaded_q;
        err_d    = 1'b0;
        pend_now = pend_q | stop;
        pend_d   = pend_now;
        cfg_ok   = (cfg_period >= TWO) && (cfg_high >= ONE) && (cfg_high < cfg_period);

        // A configuration accepted this cycle is visible to a simultaneous start.
        if (cfg_valid && state_q == IDLE) begin
            if (cfg_ok) begin
                period_d = cfg_period;
                high_d   = cfg_high;
                phase_d  = cfg_phase;
                loaded_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (loaded_d) begin
                        if (phase_d != '0) begin
                            state_d = PHASE;
                            cnt_d   = phase_d - ONE;
                        end else begin
                            state_d = HIGH;
                            cnt_d   = high_d - ONE;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PHASE: begin
                if (pend_now) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = high_q - ONE;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = period_q - high_q - ONE;
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (pend_now) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HIGH;
                        cnt_d   = high_q - ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            pend_d = 1'b0;
            if (state_q != IDLE) cnt_d = '0;
        end
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            phase_q   <= '0;
            loaded_q  <= 1'b0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            phase_q   <= phase_d;
            loaded_q  <= loaded_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            // Output register follows the HIGH state one cycle later, so the first rise lands at start+1+phase.
            clk_out_q <= (state_q == HIGH);
        end
    end

`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
        end else if (state_q == IDLE && state_d != IDLE) begin
            cycle_cnt_q <= '0;
        end else if ((state_q == HIGH) && !clk_out_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`endif

    assign cfg_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign clk_out   = clk_out_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Bench for clk_gen_ctrl: directed scenarios plus random traffic against a waveform-level reference model.
// Define CLK_GEN_CTRL_CYCLE_CNT_EN to also exercise the rising-edge counter.
module tb_clk_gen_ctrl;
    localparam int CW = 16;
    localparam int BIG = 32'h7fff_ffff;
    localparam int M_IDLE = 0, M_PH = 1, M_HI = 2, M_LO = 3;

    logic          ref_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [CW-1:0] cfg_period = '0;
    logic [CW-1:0] cfg_high = '0;
    logic [CW-1:0] cfg_phase = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          clk_out;
    logic          busy;
    logic          cfg_err;
`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
    logic [31:0]   cycle_cnt;
`endif

    clk_gen_ctrl #(.CW(CW)) dut (
        .ref_clk   (ref_clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_period(cfg_period),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .start     (start),
        .stop      (stop),
        .clk_out   (clk_out),
        .busy      (busy),
        .cfg_err   (cfg_err)
`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    always #5 ref_clk = ~ref_clk;

    int n_total = 0;
    int n_bad = 0;
    int edge_n = 0;

    // Reference model: one run described by start edge, timing fields and end edge.
    int run = 0, s0 = 0, mp = 0, mh = 0, mP = 1, t_end = BIG;
    int sh_p = 0, sh_h = 0, sh_P = 0;
    bit loaded = 0;
    bit prev_clk = 0;
    int exp_cnt = 0;

    function automatic int mst(int e);
        int r, q;
        if (run == 0 || e < s0 || e >= t_end) return M_IDLE;
        r = e - s0;
        if (r < mp) return M_PH;
        q = r - mp;
        return ((q % mP) < mh) ? M_HI : M_LO;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d edge=%0d", tag, got, exp, edge_n);
        end
    endtask

    task automatic cyc(bit cv, int per, int hi, int ph, bit st, bit sp);
        bit idle_b, err_e, clk_e;
        int r;
        cfg_valid  = cv;
        cfg_period = CW'(per);
        cfg_high   = CW'(hi);
        cfg_phase  = CW'(ph);
        start      = st;
        stop       = sp;
        @(posedge ref_clk);
        #1;
        edge_n++;
        idle_b = (mst(edge_n - 1) == M_IDLE);
        err_e  = 1'b0;
        if (idle_b && cv) begin
            if (per >= 2 && hi >= 1 && hi < per) begin
                sh_P = per; sh_h = hi; sh_p = ph; loaded = 1'b1;
            end else begin
                err_e = 1'b1;
            end
        end
        if (idle_b && st && !sp) begin
            if (loaded) begin
                run = 1; s0 = edge_n; mp = sh_p; mh = sh_h; mP = sh_P; t_end = BIG;
                exp_cnt = 0;
            end else begin
                err_e = 1'b1;
            end
        end else if (!idle_b && sp && t_end == BIG) begin
            r = edge_n - 1 - s0;
            if (r < mp) t_end = edge_n;
            else        t_end = s0 + mp + ((r - mp) / mP + 1) * mP;
        end
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        clk_e = (mst(edge_n - 1) == M_HI);
        chk("clk_out", clk_out, clk_e);
        chk("busy", busy, mst(edge_n) != M_IDLE);
        chk("cfg_ready", cfg_ready, mst(edge_n) == M_IDLE);
        chk("cfg_err", cfg_err, err_e);
`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
        if (clk_e && !prev_clk && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        chk("cycle_cnt", cycle_cnt, exp_cnt);
`endif
        prev_clk = clk_e;
    endtask

    task automatic idle_n(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_clk"}, clk_out, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, cfg_ready, 1);
        chk({tag, "_err"}, cfg_err, 0);
`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
        chk({tag, "_cnt"}, cycle_cnt, 0);
`endif
    endtask

    // Drives rst_n low between edges, holds it over two edges, releases between edges.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        run = 0; loaded = 1'b0; prev_clk = 1'b0; exp_cnt = 0; t_end = BIG;
        reset_checks("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(posedge ref_clk);
            #1;
            edge_n++;
            reset_checks("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        reset_checks("rst_init");
        @(posedge ref_clk);
        #1;
        edge_n++;
        reset_checks("rst_init2");
        rst_n = 1'b1;

        // Start with nothing configured is rejected.
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(2);

        // period=10 high=3 phase=0
        cyc(1, 10, 3, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("p10_first_low", clk_out, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("p10_first_rise", clk_out, 1);
        idle_n(32);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(14);

        // period=4 high=2 phase=5
        cyc(1, 4, 2, 5, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(24);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);

        // Invalid offers leave the last valid configuration in place.
        cyc(1, 5, 5, 0, 0, 0);
        idle_n(1);
        cyc(1, 1, 0, 0, 0, 0);
        idle_n(1);
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(16);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);

        // Start and stop together in IDLE: stop wins.
        cyc(0, 0, 0, 0, 1, 1);
        idle_n(2);

        // Configuration and start in the same cycle use the new values.
        cyc(1, 6, 2, 1, 1, 0);
        idle_n(14);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);

        // Stop in the 2nd HIGH cycle of period=8 high=4.
        cyc(1, 8, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);
        chk("stop_idle_busy", busy, 0);
        idle_n(2);

        // Asynchronous reset mid-HIGH.
        cyc(1, 8, 4, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pre_rst_high", clk_out, 1);
        do_reset();
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(2);

`ifdef CLK_GEN_CTRL_CYCLE_CNT_EN
        cyc(1, 6, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        idle_n(60);
        chk("cnt_60", cycle_cnt, 10);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);
        cyc(0, 0, 0, 0, 1, 0);
        chk("cnt_restart", cycle_cnt, 0);
        idle_n(10);
        cyc(0, 0, 0, 0, 0, 1);
        idle_n(8);
`endif

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            int per, hi, ph;
            bit cv, st, sp;
            per = int'($urandom_range(0, 12));
            hi  = int'($urandom_range(0, per + 1));
            ph  = int'($urandom_range(0, 6));
            cv  = ($urandom_range(0, 5) == 0);
            st  = ($urandom_range(0, 7) == 0);
            sp  = ($urandom_range(0, 24) == 0);
            cyc(cv, per, hi, ph, st, sp);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
